ramp_adc_ctrl: RTL
==================

Name: ramp_adc_ctrl

Overview:
Single-slope ADC conversion controller that drives the other end of the comparator path. It issues the track/hold strobe and steps the ramp DAC code. It consumes the one-cycle comparator-edge pulse produced by edge_sampler and compensates for that pulse's fixed synchronizer latency when latching the result. The converted code is delivered downstream through a valid/ready handshake.

Parameters:
WIDTH, 8, DAC code and result width in bits.
SAMPLE_CYC, 4, number of cycles sample_en is held high (range 1..255).
STEP_CYC, 2, number of cycles each DAC code is held (range 1..255).
LAT, 3, cycles from comparator switch to comp_pulse assertion; this is the edge_sampler latency (range 1..15).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  conversion request; sampled only in IDLE.
comp_pulse  input  1  one-cycle comparator-switch pulse from edge_sampler.
sample_en  output  1  track/hold strobe to the analog front end.
dac_code  output  WIDTH  ramp DAC code.
busy  output  1  high whenever the FSM is not in IDLE.
result  output  WIDTH  converted code; stable while result_valid is high.
result_valid  output  1  result available.
result_ready  input  1  downstream accepts the result.
overflow  output  1  no comparator switch occurred over the full ramp; qualified by result_valid.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0: sample_en, dac_code, busy, result, result_valid, overflow.
  - Counters and the code delay line are cleared.
  - A reset during any state aborts the conversion immediately; nothing is reported afterwards.
- IDLE:
  - Outputs are 0 except result and overflow, which hold their last values.
  - start=1 moves to SAMPLE on the next cycle.
- SAMPLE:
  - sample_en=1 and busy=1 for exactly SAMPLE_CYC cycles, then RAMP.
  - comp_pulse is ignored.
- RAMP:
  - dac_code starts at 0 and increments by 1 every STEP_CYC cycles, so code k is driven for cycles k*STEP_CYC through (k+1)*STEP_CYC-1 after RAMP entry.
  - dac_code saturates at 2^WIDTH-1; it never wraps.
- Code delay line:
  - LAT-deep shift register of dac_code, cleared to 0 on RAMP entry.
  - Its output at cycle n equals dac_code at cycle n-LAT, or 0 if n < LAT.
- DRAIN:
  - Entered after the last code (2^WIDTH-1) has been held STEP_CYC cycles.
  - Lasts LAT cycles; dac_code holds at max and comp_pulse is still accepted.
- Pulse capture:
  - comp_pulse=1 in RAMP or DRAIN latches result = delay-line output and overflow=0, then moves to DONE next cycle.
  - Only the first pulse per conversion is used.
- DRAIN expiry with no pulse: result = 2^WIDTH-1, overflow=1, move to DONE.
- DONE:
  - result_valid=1, busy=1, dac_code=0, sample_en=0.
  - On result_valid && result_ready, move to IDLE next cycle; result_valid drops that cycle.
  - result and overflow hold until the next capture.
- start outside IDLE is ignored; it is not queued.
- comp_pulse outside RAMP/DRAIN is ignored.
- start and comp_pulse in the same IDLE cycle: start is taken, the pulse is ignored.
- Conversion latency from start to result_valid: 1 + SAMPLE_CYC + (capture cycle) + 1 cycles.
- Back-to-back operation: start may be asserted in the first IDLE cycle after a handshake.

Test Plan:
(All scenarios use WIDTH=4, SAMPLE_CYC=4, STEP_CYC=2, LAT=3.)
1. Reset: hold rst=0 for 3 cycles, then release -> all outputs 0 and busy=0; start held low -> nothing changes for 20 cycles.
2. Nominal conversion:
   - Stimulus: start pulse; comparator switches on the first cycle dac_code=5; edge_sampler model delivers comp_pulse 3 cycles later.
   - Required: sample_en high exactly 4 cycles; result=5, overflow=0, result_valid next cycle.
   - Hold result_ready=0 for 5 cycles -> result stays stable; assert result_ready -> IDLE next cycle.
3. Edge codes:
   - Switch during code 0 -> result=0.
   - Switch on the last cycle of code 15 (pulse arrives in DRAIN) -> result=15, overflow=0.
4. Overflow: no comp_pulse -> RAMP+DRAIN lasts 35 cycles, then result=15, overflow=1, result_valid=1.
5. Spurious inputs:
   - comp_pulse during SAMPLE and DONE is ignored.
   - A second pulse in RAMP does not change result.
   - start during busy does not restart the conversion.
6. Abort and back-to-back:
   - rst=0 mid-RAMP at dac_code=7 -> outputs 0 immediately and no result_valid after release.
   - Two back-to-back conversions (switches at codes 3 and 12) -> results 3 then 12.

Source files
------------

// File: rtl/ramp_adc_ctrl_if.sv
// rtl/ramp_adc_ctrl_if.sv - analog-side strobes and result handshake of the ramp ADC controller
interface ramp_adc_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             comp_pulse;
    logic             sample_en;
    logic [WIDTH-1:0] dac_code;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             result_ready;
    logic             overflow;

    // Controller side
    modport master (
        input  start,
        input  comp_pulse,
        input  result_ready,
        output sample_en,
        output dac_code,
        output busy,
        output result,
        output result_valid,
        output overflow
    );

    // Requester / front-end / downstream side
    modport slave (
        output start,
        output comp_pulse,
        output result_ready,
        input  sample_en,
        input  dac_code,
        input  busy,
        input  result,
        input  result_valid,
        input  overflow
    );
endinterface

// File: rtl/ramp_adc_ctrl.sv
// rtl/ramp_adc_ctrl.sv - single-slope ADC controller: track/hold, DAC ramp, latency-compensated capture
module ramp_adc_ctrl #(
    parameter int WIDTH      = 8,
    parameter int SAMPLE_CYC = 4,
    parameter int STEP_CYC   = 2,
    parameter int LAT        = 3
) (
    input  logic             clk,
    input  logic             rst,
    ramp_adc_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        RAMP   = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] CODE_MAX    = '1;
    localparam logic [7:0]       SAMPLE_LAST = 8'(SAMPLE_CYC - 1);
    localparam logic [7:0]       STEP_LAST   = 8'(STEP_CYC - 1);
    localparam logic [7:0]       DRAIN_LAST  = 8'(LAT - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic [WIDTH-1:0] dl_q [LAT];
    logic [WIDTH-1:0] dl_d [LAT];
    logic [WIDTH-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             sample_en_q, sample_en_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    // The oldest delay-line entry is the code that was on the DAC when the
    // comparator actually switched, LAT cycles before its pulse shows up.
    logic [WIDTH-1:0] dl_out;
    assign dl_out = dl_q[LAT-1];

    // Next-state, counter, ramp, delay-line and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dac_d      = dac_q;
        dl_d       = dl_q;
        result_d   = result_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SAMPLE;
                    cnt_d   = 8'd0;
                end
            end

            SAMPLE: begin
                if (cnt_q == SAMPLE_LAST) begin
                    state_d = RAMP;
                    cnt_d   = 8'd0;
                    dac_d   = '0;
                    for (int i = 0; i < LAT; i++) begin
                        dl_d[i] = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            RAMP: begin
                dl_d[0] = dac_q;
                for (int i = 1; i < LAT; i++) begin
                    dl_d[i] = dl_q[i-1];
                end
                if (bus.comp_pulse) begin
                    result_d   = dl_out;
                    overflow_d = 1'b0;
                    dac_d      = '0;
                    state_d    = DONE;
                end else if (cnt_q == STEP_LAST) begin
                    cnt_d = 8'd0;
                    // The top code gets its full hold time before draining;
                    // the ramp saturates rather than wrapping.
                    if (dac_q == CODE_MAX) begin
                        state_d = DRAIN;
                    end else begin
                        dac_d = dac_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            DRAIN: begin
                // Keep shifting so a switch during the last codes still
                // resolves to the code that caused it.
                dl_d[0] = dac_q;
                for (int i = 1; i < LAT; i++) begin
                    dl_d[i] = dl_q[i-1];
                end
                if (bus.comp_pulse) begin
                    result_d   = dl_out;
                    overflow_d = 1'b0;
                    dac_d      = '0;
                    state_d    = DONE;
                end else if (cnt_q == DRAIN_LAST) begin
                    result_d   = CODE_MAX;
                    overflow_d = 1'b1;
                    dac_d      = '0;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            DONE: begin
                if (bus.result_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                dac_d   = '0;
            end
        endcase

        sample_en_d = (state_d == SAMPLE);
        busy_d      = (state_d != IDLE);
        valid_d     = (state_d == DONE);
    end

    // State and registered outputs; reset aborts any conversion in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            dac_q       <= '0;
            for (int i = 0; i < LAT; i++) begin
                dl_q[i] <= '0;
            end
            result_q    <= '0;
            overflow_q  <= 1'b0;
            sample_en_q <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dac_q       <= dac_d;
            dl_q        <= dl_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            sample_en_q <= sample_en_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
        end
    end

    assign bus.sample_en    = sample_en_q;
    assign bus.dac_code     = dac_q;
    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.overflow     = overflow_q;
endmodule
